// File: rtl/rca_seq_ctrl_if.sv
// Requester-side bundle for rca_seq_ctrl: operation request plus result.
// The master is the requesting ALU/FSM; the slave is the sequencer.
interface rca_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Nibble-serial add/subtract sequencer driving one external 4-bit RCA slice.
// Operands are latched on start; one slice result is captured per cycle, LSB first.
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    rca_seq_ctrl_if.slave      req,
    output logic [3:0]         rca_a,
    output logic [3:0]         rca_b,
    output logic               rca_cin,
    input  logic [3:0]         rca_sum,
    input  logic               rca_cout
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int MSB    = WIDTH - 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [IW+1:0]    lo;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic             run;

    assign lo  = {idx, 2'b00};
    assign run = (state == RUN);

    assign rca_a   = run ? a_reg[lo +: 4] : 4'h0;
    assign rca_b   = run ? b_reg[lo +: 4] : 4'h0;
    assign rca_cin = run ? carry : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            req.busy <= 1'b0;
            req.done <= 1'b0;
            req.sum  <= '0;
            req.cout <= 1'b0;
            req.ovf  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req.start) begin
                        a_reg    <= req.a;
                        b_reg    <= req.sub ? ~req.b : req.b;
                        carry    <= req.sub | req.cin;
                        idx      <= '0;
                        req.sum  <= '0;
                        req.cout <= 1'b0;
                        req.ovf  <= 1'b0;
                        req.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    req.sum[lo +: 4] <= rca_sum;
                    carry            <= rca_cout;
                    if (idx == LAST) begin
                        // Top slice result is still on rca_sum, so flags
                        // can be registered together with the last nibble.
                        req.cout <= rca_cout;
                        req.ovf  <= (a_reg[MSB] == b_reg[MSB]) &&
                                    (rca_sum[3] != a_reg[MSB]);
                        req.busy <= 1'b0;
                        req.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    req.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    req.busy <= 1'b0;
                    req.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed and random checks of rca_seq_ctrl at WIDTH=16 and WIDTH=32,
// each instance paired with a behavioural 4-bit ripple-carry slice.
module tb_rca_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rca_seq_ctrl_if #(.WIDTH(16)) i16 ();
    rca_seq_ctrl_if #(.WIDTH(32)) i32 ();

    logic [3:0] ra16, rb16, rs16, ra32, rb32, rs32;
    logic       rc16, co16, rc32, co32;

    assign {co16, rs16} = {1'b0, ra16} + {1'b0, rb16} + {4'b0, rc16};
    assign {co32, rs32} = {1'b0, ra32} + {1'b0, rb32} + {4'b0, rc32};

    rca_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (i16.slave),
        .rca_a    (ra16),
        .rca_b    (rb16),
        .rca_cin  (rc16),
        .rca_sum  (rs16),
        .rca_cout (co16)
    );

    rca_seq_ctrl #(.WIDTH(32)) dut32 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (i32.slave),
        .rca_a    (ra32),
        .rca_b    (rb32),
        .rca_cin  (rc32),
        .rca_sum  (rs32),
        .rca_cout (co32)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sb,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic c);
        i16.start = st;
        i32.start = st;
        i16.sub   = sb;
        i32.sub   = sb;
        i16.a     = a[15:0];
        i32.a     = a;
        i16.b     = b[15:0];
        i32.b     = b;
        i16.cin   = c;
        i32.cin   = c;
    endtask

    // Whole-word reference: {ovf, cout, sum}
    function automatic logic [17:0] ref16(input logic sb, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        logic [15:0] bb;
        logic [16:0] f;
        bb = sb ? ~b : b;
        f  = {1'b0, a} + {1'b0, bb} + {16'b0, sb | c};
        return {(a[15] == bb[15]) && (f[15] != a[15]), f[16], f[15:0]};
    endfunction

    function automatic logic [33:0] ref32(input logic sb, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [31:0] bb;
        logic [32:0] f;
        bb = sb ? ~b : b;
        f  = {1'b0, a} + {1'b0, bb} + {32'b0, sb | c};
        return {(a[31] == bb[31]) && (f[31] != a[31]), f[32], f[31:0]};
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] x, input int i);
        return x[4*i +: 4];
    endfunction

    task automatic do_op(input logic sb, input logic [31:0] a,
                         input logic [31:0] b, input logic c,
                         input logic [15:0] es, input logic ec,
                         input logic ev);
        int          d16;
        int          d32;
        logic [15:0] s16;
        logic [31:0] s32;
        logic        c16, v16, c32, v32;
        logic [33:0] r;
        d16 = 0;
        d32 = 0;
        s16 = 'x;
        s32 = 'x;
        {c16, v16, c32, v32} = 'x;
        @(negedge clk);
        drive(1'b1, sb, a, b, c);
        @(negedge clk);
        drive(1'b0, ~sb, ~a, ~b, ~c);
        for (int k = 1; k <= 12; k++) begin
            if (i16.done) begin
                d16 = k;
                s16 = i16.sum;
                c16 = i16.cout;
                v16 = i16.ovf;
            end
            if (i32.done) begin
                d32 = k;
                s32 = i32.sum;
                c32 = i32.cout;
                v32 = i32.ovf;
            end
            @(negedge clk);
        end
        chk("lat16", d16, 5);
        chk("lat32", d32, 9);
        chk("sum16", s16, es);
        chk("cout16", c16, ec);
        chk("ovf16", v16, ev);
        chk("hold16", i16.sum, es);
        r = ref32(sb, a, b, c);
        chk("sum32", s32, r[31:0]);
        chk("cout32", c32, r[32]);
        chk("ovf32", v32, r[33]);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs, rc;
        logic [17:0] e;

        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_busy", i16.busy, 0);
        chk("rst_done", i16.done, 0);
        chk("rst_sum", i16.sum, 0);
        chk("rst_cout", i16.cout, 0);
        chk("rst_ovf", i16.ovf, 0);
        chk("rst_rca_a", ra16, 0);
        rst_n = 1'b1;

        // Per-cycle slice stepping and latency for 0x1234 + 0x4321
        @(negedge clk);
        chk("idle_rca_a", ra16, 0);
        drive(1'b1, 1'b0, 32'h1234, 32'h4321, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            chk("run_busy", i16.busy, 1);
            chk("run_done", i16.done, 0);
            chk("run_rca_a", ra16, nib(16'h1234, k - 1));
            chk("run_rca_b", rb16, nib(16'h4321, k - 1));
            chk("run_rca_cin", rc16, 0);
            @(negedge clk);
        end
        chk("done_pulse", i16.done, 1);
        chk("done_busy", i16.busy, 0);
        chk("done_sum", i16.sum, 16'h5555);
        chk("done_cout", i16.cout, 0);
        chk("done_ovf", i16.ovf, 0);
        chk("done_rca_a", ra16, 0);
        chk("done_rca_b", rb16, 0);
        @(negedge clk);
        chk("post_done", i16.done, 0);
        chk("post_sum", i16.sum, 16'h5555);
        repeat (6) @(negedge clk);

        do_op(1'b0, 32'hFFFF, 32'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(1'b0, 32'h7FFF, 32'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
        do_op(1'b1, 32'h0005, 32'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        do_op(1'b1, 32'h0005, 32'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(1'b1, 32'h8000, 32'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);

        // start held high: one accepted op every 6 cycles
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0011, 32'h0022, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            chk("stream_done", i16.done, (k % 6) == 5);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("stream_sum", i16.sum, 16'h0033);
        repeat (12) @(negedge clk);

        // Reset in the 3rd RUN cycle aborts the operation
        drive(1'b1, 1'b0, 32'h00F0, 32'h0F00, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", i16.busy, 0);
        chk("abort_done", i16.done, 0);
        chk("abort_sum", i16.sum, 0);
        chk("abort_cout", i16.cout, 0);
        chk("abort_ovf", i16.ovf, 0);
        for (int k = 0; k < 8; k++) begin
            chk("abort_nodone", i16.done, 0);
            @(negedge clk);
        end
        do_op(1'b0, 32'h00F0, 32'h0F00, 1'b0, 16'h0FF0, 1'b0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            e  = ref16(rs, ra[15:0], rb[15:0], rc);
            do_op(rs, ra, rb, rc, e[15:0], e[16], e[17]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single external 4-bit ripple-carry slice, one nibble per cycle, LSB first. It latches operands on a start handshake and drives the slice inputs. It captures slice sum/carry into a result register and a carry register, then pulses done with sum, carry-out and signed overflow. It sits between a requester (ALU/control FSM) and one 4-bit RCA instance.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8
NSLICE, WIDTH/4, derived local constant: number of slice cycles per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b+cin, 1 = a-b (cin ignored); latched with start
a  input  WIDTH  operand A; latched with start
b  input  WIDTH  operand B; latched with start
cin  input  1  carry-in for add; latched with start
rca_a  output  4  slice operand A nibble
rca_b  output  4  slice operand B nibble (already inverted when sub)
rca_cin  output  1  slice carry-in
rca_sum  input  4  slice sum (combinational from rca_a/rca_b/rca_cin)
rca_cout  input  1  slice carry-out
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, result valid
sum  output  WIDTH  result; held until next accepted start
cout  output  1  final carry (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, idx 0, all registers 0; busy, done, sum, cout, ovf = 0. Reset during RUN or DONE aborts the operation, no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge -> a_reg <= a; b_reg <= sub ? ~b : b; carry <= sub ? 1 : cin; sub_reg <= sub; idx <= 0; -> RUN. start=0 -> stay.
- RUN: rca_a = a_reg[4*idx+3:4*idx], rca_b = b_reg nibble idx, rca_cin = carry (all combinational from registers). At each edge: sum nibble idx <= rca_sum; carry <= rca_cout; idx <= idx+1. When idx == NSLICE-1 -> DONE, else stay.
- DONE: done=1 for exactly this cycle; cout = carry; ovf = (a_reg[MSB] == b_reg[MSB]) && (sum[MSB] != a_reg[MSB]). Next edge -> IDLE unconditionally.
- Outside RUN: rca_a, rca_b, rca_cin driven 0.
- Latency: start sampled at edge E0; slices occupy cycles after E0 .. E0+NSLICE; done high in the cycle after edge E0+NSLICE (WIDTH=16: done in the 5th cycle after the start edge). Throughput: one operation per NSLICE+2 cycles.
- start while RUN or DONE: ignored, no queueing; operand inputs may change freely after acceptance.
- sum/cout/ovf: cleared to 0 when a new start is accepted. sum updates nibble-by-nibble during RUN and is stable only when done=1. All three hold afterwards until the next accepted start or reset.
- idx width = clog2(NSLICE); no wrap beyond NSLICE-1.
- cin has no effect when sub=1.

Test Plan:
- WIDTH=16, add 0x1234+0x4321, cin=0 -> done 5 cycles after start edge, sum=0x5555, cout=0, ovf=0; busy high for exactly 4 cycles.
- Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Add 0x7FFF+0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
- Sub 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1. Cin=1 applied with sub has no effect.
- Start held high continuously -> ops accepted every 6 cycles. Operands changed during RUN do not alter the result. Check per cycle that rca_a/rca_b step nibbles 0..3 and are 0 in IDLE/DONE.
- rst_n low for one edge during 3rd RUN cycle -> next cycle busy=0, done never pulses, sum=0, cout=0, ovf=0. A following start completes normally.
- Random regression, 1000 ops with WIDTH=16 and WIDTH=32, bench using a behavioural 4-bit RCA: sum/cout/ovf match a reference a±b model on every done pulse.
